data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, handshaked successor of the single-cycle data memory.
- Little-endian byte-addressed store built from 4 byte-lane banks of DEPTH_BYTES/4 entries each.
- Accepts one load/store request at a time over valid/ready and returns a registered response.
- Splits word-crossing misaligned accesses into two bank cycles and flags out-of-range or illegal accesses instead of corrupting memory; sits between the LSU and the bus.

Parameters:
- DEPTH_BYTES, 1024, storage size in bytes; power of two, multiple of 4, >= 8.
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two phases; 0 = report misaligned accesses as errors.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_ctrl  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bytes used for B/H.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  access rejected; valid with rsp_valid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - Memory contents are not cleared by reset; they are zero-initialised at time 0 only.
- States: IDLE, ACC0, ACC1.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready at a rising edge. The request fields are latched on accept; inputs are ignored while busy.
- Error checks, decoded at accept:
  - illegal ctrl: 011, 110, 111;
  - store with ctrl 100/101;
  - last byte address (addr + size - 1) >= DEPTH_BYTES, where size is 1/2/4;
  - ALLOW_MISALIGNED=0 and (H with addr[0]=1, or W with addr[1:0]!=0).
  - Any error: no bank is written; next state ACC0 without bank access; response has rsp_error=1, rsp_rdata=0.
- ACC0 (at the edge leaving it):
  - Access word index addr[AW-1:2] on lanes addr[1:0] .. min(3, addr[1:0]+size-1).
  - Stores write the enabled lanes with bytes taken in order from req_wdata[7:0] upward.
  - Loads capture the enabled lanes.
  - If the access crosses a word boundary (addr[1:0]+size > 4), go to ACC1. Otherwise go to IDLE and assert the response.
- ACC1: access word index+1, lanes 0 .. (addr[1:0]+size-5), continuing the byte sequence. Then go to IDLE and assert the response.
- Response:
  - rsp_valid=1 for exactly the cycle after the last access edge, coinciding with IDLE, so req_ready=1 in the same cycle.
  - Latency from accept edge: 1 edge for non-crossing or error, 2 for crossing.
  - Peak throughput is 1 request per 2 cycles.
- Load result assembly:
  - Bytes are assembled little-endian from addr.
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is taken as-is.
- Stores: rsp_valid=1, rsp_error=0, rsp_rdata=0.
- rsp_rdata and rsp_error hold their values until the next response or reset; they are meaningful only when rsp_valid=1.
- Read/write ordering: a load issued after a store always sees the stored data.
- Reset mid-operation: the state machine aborts with no response. Bytes committed in ACC0 remain; ACC1 bytes are not written.
- Address bits above log2(DEPTH_BYTES) participate only in the range check.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, followed by LW 0x10 -> each response arrives 1 edge after accept, rsp_error=0, LW rsp_rdata=0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LHU 0x12 -> 0x0000DEAD.
- ALLOW_MISALIGNED=1: SW addr 0x1E data 0x11223344, then LW 0x1E -> each response 2 edges after accept, rdata=0x11223344; LW 0x1C -> 0x33440000, LW 0x20 -> 0x00001122.
- ALLOW_MISALIGNED=0: LH 0x21 and SW 0x22 -> rsp_error=1, rdata=0; a following LW 0x20 confirms no bytes changed.
- Range/illegal: LW 0x3FD (DEPTH_BYTES=1024) -> error; SB 0x3FF 0xAB -> ok, and LBU 0x3FF -> 0xAB; ctrl=011 -> error; store with ctrl=100 -> error.
- Handshake: hold req_valid high with a stream of requests -> accepts only while req_ready=1, and no request is lost or duplicated against the scoreboard.
- Assert rst_n=0 during ACC1 of misaligned SW 0x1E 0xAABBCCDD -> rsp_valid never pulses, req_ready=1 after release, bytes 0x1E/0x1F = DD/CC, bytes 0x20/0x21 unchanged.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Handshaked little-endian data memory: four byte-lane banks, one request in flight,
// word-crossing accesses split into two bank cycles, illegal/out-of-range accesses flagged.
module data_memory_ctrl #(
    parameter int unsigned DEPTH_BYTES      = 1024,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned WW    = AW - 2;
    localparam int unsigned WORDS = DEPTH_BYTES / 4;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_e;

    function automatic logic [2:0] size_of(input logic [1:0] sz_code);
        case (sz_code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] raw);
        case (ctrl)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [1:0]      off_q, off_d;
    logic [WW-1:0]   widx_q, widx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rbuf_q, rbuf_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;

    logic            req_err;
    logic [2:0]      size_in;
    logic [32:0]     last_addr;
    logic [2:0]      size_cur;
    logic            phase;
    logic            crossing;
    logic [WW-1:0]   widx;
    logic [3:0]      lane_en;
    logic [3:0]      bank_we;
    logic [3:0][7:0] wbyte;
    logic [3:0][7:0] rd_byte;
    logic [31:0]     assembled;

    // Request legality, decoded from the live inputs so it can be latched on accept.
    always_comb begin
        size_in   = size_of(req_ctrl[1:0]);
        last_addr = {1'b0, req_addr} + {30'h0, size_in} - 33'd1;
        req_err   = (req_ctrl inside {3'b011, 3'b110, 3'b111})
                  || (req_write && req_ctrl[2])
                  || (last_addr >= 33'(DEPTH_BYTES))
                  || ((ALLOW_MISALIGNED == 1'b0)
                      && ((req_ctrl[1:0] == 2'b01 && req_addr[0])
                          || (req_ctrl[1:0] == 2'b10 && req_addr[1:0] != 2'b00)));
    end

    // Lane k of the access sequence: byte k sits at address addr+k, i.e. lane (off+k) mod 4.
    always_comb begin : p_lanes
        int         k;
        logic [1:0] kk;
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        k         = 0;
        kk        = 2'd0;
        lane_en   = '0;
        wbyte     = '0;
        size_cur  = size_of(ctrl_q[1:0]);
        phase     = (state_q == ACC1);
        crossing  = ({1'b0, off_q} + size_cur) > 3'd4;
        widx      = phase ? widx_q + WW'(1) : widx_q;
        assembled = phase ? rbuf_q : 32'h0;
        for (int l = 0; l < 4; l++) begin
            k  = l + (phase ? 4 : 0) - int'(off_q);
            kk = 2'(k);
            lane_en[l] = (state_q != IDLE) && !err_q && (k >= 0) && (k < int'(size_cur));
            if (lane_en[l]) begin
                wbyte[l] = wdata_q[{kk, 3'b000} +: 8];
                assembled[{kk, 3'b000} +: 8] = rd_byte[l];
            end
        end
        bank_we = lane_en & {4{write_q}};
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        // NOTE: storage has no reset; contents only start at zero and survive rst_n.
        logic [7:0] bank [WORDS] = '{default: 8'h00};

        always_ff @(posedge clk) begin
            if (bank_we[l]) begin
                bank[widx] <= wbyte[l];
            end
        end

        assign rd_byte[l] = bank[widx];
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        ctrl_d      = ctrl_q;
        off_d       = off_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rbuf_d      = rbuf_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    ctrl_d  = req_ctrl;
                    off_d   = req_addr[1:0];
                    widx_d  = req_addr[AW-1:2];
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    state_d = ACC0;
                end
            end
            ACC0, ACC1: begin
                if (state_q == ACC0 && !err_q && crossing) begin
                    rbuf_d  = assembled;
                    state_d = ACC1;
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = err_q;
                    rsp_rdata_d = (err_q || write_q) ? 32'h0 : extend(ctrl_q, assembled);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            ctrl_q      <= 3'b000;
            off_q       <= 2'b00;
            widx_q      <= '0;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            rbuf_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            ctrl_q      <= ctrl_d;
            off_q       <= off_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rbuf_q      <= rbuf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance with misaligned splitting, one without,
// both checked against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_a, req_ready_b;
    logic        req_write = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_error_a, rsp_error_b;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ALLOW_MISALIGNED(1'b1)) u_dut_ma (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_error(rsp_error_a)
    );

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .ALLOW_MISALIGNED(1'b0)) u_dut_al (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mem_m [2][DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: a request touches bytes addr .. addr+size-1 one at a time.
    task automatic model_req(input int m, input bit wr, input logic [2:0] ctrl,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output bit err, output logic [31:0] rd, output int lat);
        int size;
        longint last;
        logic [31:0] raw;
        size = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
        last = longint'({32'h0, addr}) + size - 1;
        err  = (ctrl inside {3'd3, 3'd6, 3'd7}) || (wr && ctrl[2]) || (last >= DEPTH)
            || (m == 0 && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00)));
        rd  = 32'h0;
        raw = 32'h0;
        lat = 1;
        if (!err) begin
            if (int'(addr[1:0]) + size > 4) lat = 2;
            for (int i = 0; i < size; i++) begin
                if (wr) mem_m[m][int'(addr) + i] = wd[8*i +: 8];
                else    raw[8*i +: 8] = mem_m[m][int'(addr) + i];
            end
            if (!wr) begin
                case (ctrl)
                    3'd0:    rd = {{24{raw[7]}}, raw[7:0]};
                    3'd1:    rd = {{16{raw[15]}}, raw[15:0]};
                    3'd4:    rd = {24'h0, raw[7:0]};
                    3'd5:    rd = {16'h0, raw[15:0]};
                    default: rd = raw;
                endcase
            end
        end
    endtask

    // One request into both instances; checks latency, single pulse, error and data.
    task automatic do_req(input bit wr, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd_a, output logic [31:0] rd_b);
        bit e_a, e_b;
        logic [31:0] x_a, x_b;
        int l_a, l_b, gl_a, gl_b, p_a, p_b;
        logic ge_a, ge_b;
        model_req(1, wr, ctrl, addr, wd, e_a, x_a, l_a);
        model_req(0, wr, ctrl, addr, wd, e_b, x_b, l_b);
        gl_a = 0; gl_b = 0; p_a = 0; p_b = 0; ge_a = 1'b0; ge_b = 1'b0;
        rd_a = 32'hx; rd_b = 32'hx;
        @(negedge clk);
        check("ready_a", 32'(req_ready_a), 32'd1);
        check("ready_b", 32'(req_ready_b), 32'd1);
        req_write = wr; req_ctrl = ctrl; req_addr = addr; req_wdata = wd;
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_a) begin p_a++; gl_a = n; rd_a = rsp_rdata_a; ge_a = rsp_error_a; end
            if (rsp_valid_b) begin p_b++; gl_b = n; rd_b = rsp_rdata_b; ge_b = rsp_error_b; end
        end
        check("lat_a", 32'(gl_a), 32'(l_a));
        check("lat_b", 32'(gl_b), 32'(l_b));
        check("pulses_a", 32'(p_a), 32'd1);
        check("pulses_b", 32'(p_b), 32'd1);
        check("err_a", 32'(ge_a), 32'(e_a));
        check("err_b", 32'(ge_b), 32'(e_b));
        check("rdata_a", rd_a, x_a);
        check("rdata_b", rd_b, x_b);
    endtask

    task automatic rand_req(output bit wr, output logic [2:0] ctrl,
                            output logic [31:0] addr, output logic [31:0] wd);
        int r;
        wr   = 1'($urandom_range(0, 1));
        ctrl = 3'($urandom_range(0, 7));
        if ((ctrl inside {3'd3, 3'd6, 3'd7}) && $urandom_range(0, 3) != 0) ctrl = 3'd2;
        r = $urandom_range(0, 9);
        if (r < 7)       addr = 32'($urandom_range(0, 63));
        else if (r < 9)  addr = 32'($urandom_range(DEPTH - 8, DEPTH - 1));
        else             addr = $urandom;
        wd = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, pre;
        bit wr;
        logic [2:0] ct;
        logic [31:0] ad, wd;

        foreach (mem_m[m, a]) mem_m[m][a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready_a), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_rdata", rsp_rdata_a, 32'h0);
        check("rst_error", 32'(rsp_error_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned word store and narrow loads.
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, ra, rb);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, ra, rb);
        check("lw_10", ra, 32'hDEADBEEF);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, ra, rb);
        check("lb_13", ra, 32'hFFFFFFDE);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, ra, rb);
        check("lbu_13", ra, 32'h000000DE);
        do_req(1'b0, 3'd5, 32'h12, 32'h0, ra, rb);
        check("lhu_12", ra, 32'h0000DEAD);

        // Word-crossing accesses.
        do_req(1'b1, 3'd2, 32'h1E, 32'h11223344, ra, rb);
        do_req(1'b0, 3'd2, 32'h1E, 32'h0, ra, rb);
        check("lw_1e", ra, 32'h11223344);
        do_req(1'b0, 3'd2, 32'h1C, 32'h0, ra, rb);
        check("lw_1c", ra, 32'h33440000);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, ra, rb);
        check("lw_20", ra, 32'h00001122);

        // Misaligned rejected when splitting is disabled.
        do_req(1'b0, 3'd1, 32'h21, 32'h0, ra, rb);
        do_req(1'b1, 3'd2, 32'h22, 32'h55667788, ra, rb);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, ra, rb);
        check("al_lw_20", rb, 32'h0);

        // Range and illegal encodings.
        do_req(1'b0, 3'd2, 32'h3FD, 32'h0, ra, rb);
        do_req(1'b1, 3'd0, 32'h3FF, 32'h000000AB, ra, rb);
        do_req(1'b0, 3'd4, 32'h3FF, 32'h0, ra, rb);
        check("lbu_3ff_a", ra, 32'h000000AB);
        check("lbu_3ff_b", rb, 32'h000000AB);
        do_req(1'b0, 3'd3, 32'h0, 32'h0, ra, rb);
        do_req(1'b1, 3'd4, 32'h4, 32'h12345678, ra, rb);
        do_req(1'b0, 3'd2, 32'h4, 32'h0, ra, rb);

        // Reset during the second phase of a split store.
        pre = {mem_m[1][32'h23], mem_m[1][32'h22], mem_m[1][32'h21], mem_m[1][32'h20]};
        @(negedge clk);
        req_write = 1'b1; req_ctrl = 3'd2; req_addr = 32'h1E; req_wdata = 32'hAABBCCDD;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        @(posedge clk);
        #1;
        check("abort_no_rsp0", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready_rst", 32'(req_ready_a), 32'd1);
        check("abort_no_rsp1", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp2", 32'(rsp_valid_a), 32'd0);
        end
        check("abort_ready", 32'(req_ready_a), 32'd1);
        mem_m[1][32'h1E] = 8'hDD;
        mem_m[1][32'h1F] = 8'hCC;
        do_req(1'b0, 3'd2, 32'h1C, 32'h0, ra, rb);
        check("abort_1e_1f", {16'h0, ra[31:16]}, 32'h0000CCDD);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, ra, rb);
        check("abort_20_23", ra, pre);

        // Randomised serial traffic into both instances.
        for (int t = 0; t < 250; t++) begin
            rand_req(wr, ct, ad, wd);
            do_req(wr, ct, ad, wd, ra, rb);
        end

        // Back-to-back stream with req_valid held high.
        begin
            localparam int NS = 40;
            bit          s_wr [NS];
            logic [2:0]  s_ct [NS];
            logic [31:0] s_ad [NS];
            logic [31:0] s_wd [NS];
            logic [31:0] exp_q [$];
            bit          experr_q [$];
            int idx, got, lat;
            bit rdy, e;
            logic [31:0] x;
            for (int i = 0; i < NS; i++) rand_req(s_wr[i], s_ct[i], s_ad[i], s_wd[i]);
            idx = 0;
            got = 0;
            for (int cyc = 0; cyc < 400 && got < NS; cyc++) begin
                @(negedge clk);
                if (idx < NS) begin
                    req_write = s_wr[idx]; req_ctrl = s_ct[idx];
                    req_addr = s_ad[idx]; req_wdata = s_wd[idx];
                    req_valid_a = 1'b1;
                    rdy = req_ready_a;
                end else begin
                    req_valid_a = 1'b0;
                    rdy = 1'b0;
                end
                @(posedge clk);
                if (rdy) begin
                    model_req(1, s_wr[idx], s_ct[idx], s_ad[idx], s_wd[idx], e, x, lat);
                    exp_q.push_back(x);
                    experr_q.push_back(e);
                    idx++;
                end
                #1;
                if (rsp_valid_a) begin
                    if (exp_q.size() == 0) begin
                        check("stream_spurious", 32'd1, 32'd0);
                    end else begin
                        check("stream_rdata", rsp_rdata_a, exp_q.pop_front());
                        check("stream_err", 32'(rsp_error_a), 32'(experr_q.pop_front()));
                    end
                    got++;
                end
            end
            req_valid_a = 1'b0;
            check("stream_accepted", 32'(idx), 32'(NS));
            check("stream_responses", 32'(got), 32'(NS));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
